// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - two-port arbitrated front end for a shared 64-bit ALU
// Optional macro ALU_ARB_FIXED_PRIO_EN: port 0 always wins contention instead of round-robin.
module alu_share_arbiter #(
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             p0_valid,
   output logic             p0_ready,
   input  logic [63:0]      p0_a,
   input  logic [63:0]      p0_b,
   input  logic [3:0]       p0_op,
   input  logic [TAG_W-1:0] p0_tag,
   input  logic             p1_valid,
   output logic             p1_ready,
   input  logic [63:0]      p1_a,
   input  logic [63:0]      p1_b,
   input  logic [3:0]       p1_op,
   input  logic [TAG_W-1:0] p1_tag,
   output logic             r0_valid,
   input  logic             r0_ready,
   output logic [63:0]      r0_result,
   output logic             r0_zero,
   output logic [TAG_W-1:0] r0_tag,
   output logic             r1_valid,
   input  logic             r1_ready,
   output logic [63:0]      r1_result,
   output logic             r1_zero,
   output logic [TAG_W-1:0] r1_tag,
   output logic             busy
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_EXEC = 2'd1;
   localparam logic [1:0] S_HOLD = 2'd2;

   logic [1:0]       state;
   logic             gnt;
   logic [63:0]      a_q;
   logic [63:0]      b_q;
   logic [3:0]       op_q;
   logic [TAG_W-1:0] tag_q;
   logic             sel;
   logic             accept;
   logic             resp_done;
   logic [63:0]      alu_res;
`ifndef ALU_ARB_FIXED_PRIO_EN
   logic             last_grant;
`endif

   // sel picks the port that would be granted if we accept this cycle
   always_comb begin
      sel = 1'b0;
      if (p1_valid && !p0_valid)
         sel = 1'b1;
`ifndef ALU_ARB_FIXED_PRIO_EN
      else if (p0_valid && p1_valid)
         sel = ~last_grant;
`endif
   end

   assign accept    = (state == S_IDLE) && (p0_valid || p1_valid);
   assign p0_ready  = accept && !sel;
   assign p1_ready  = accept && sel;
   assign busy      = (state != S_IDLE);
   assign resp_done = gnt ? (r1_valid && r1_ready) : (r0_valid && r0_ready);

   always_comb begin
      alu_res = 64'd0;
      case (op_q)
         4'b0000: alu_res = a_q & b_q;
         4'b0001: alu_res = a_q | b_q;
         4'b0010: alu_res = a_q + b_q;
         4'b0110: alu_res = a_q - b_q;
         4'b1100: alu_res = ~(a_q | b_q);
         4'b1111: alu_res = (a_q < b_q) ? 64'd0 : 64'd1;
         default: alu_res = 64'd0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         gnt       <= 1'b0;
         a_q       <= 64'd0;
         b_q       <= 64'd0;
         op_q      <= 4'd0;
         tag_q     <= '0;
         r0_valid  <= 1'b0;
         r0_result <= 64'd0;
         r0_zero   <= 1'b0;
         r0_tag    <= '0;
         r1_valid  <= 1'b0;
         r1_result <= 64'd0;
         r1_zero   <= 1'b0;
         r1_tag    <= '0;
`ifndef ALU_ARB_FIXED_PRIO_EN
         last_grant <= 1'b1;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               if (accept) begin
                  gnt   <= sel;
                  a_q   <= sel ? p1_a : p0_a;
                  b_q   <= sel ? p1_b : p0_b;
                  op_q  <= sel ? p1_op : p0_op;
                  tag_q <= sel ? p1_tag : p0_tag;
`ifndef ALU_ARB_FIXED_PRIO_EN
                  last_grant <= sel;
`endif
                  state <= S_EXEC;
               end
            end
            S_EXEC: begin
               // only the granted port's response registers are written
               if (gnt) begin
                  r1_valid  <= 1'b1;
                  r1_result <= alu_res;
                  r1_zero   <= (alu_res == 64'd0);
                  r1_tag    <= tag_q;
               end else begin
                  r0_valid  <= 1'b1;
                  r0_result <= alu_res;
                  r0_zero   <= (alu_res == 64'd0);
                  r0_tag    <= tag_q;
               end
               state <= S_HOLD;
            end
            S_HOLD: begin
               if (resp_done) begin
                  if (gnt)
                     r1_valid <= 1'b0;
                  else
                     r0_valid <= 1'b0;
                  state <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - directed self-checking bench for alu_share_arbiter
// Define ALU_ARB_FIXED_PRIO_EN to match a fixed-priority DUT build.
module tb_alu_share_arbiter;

   localparam int TAG_W = 4;

   logic             clk;
   logic             rst_n;
   logic             p0_valid, p1_valid;
   logic             p0_ready, p1_ready;
   logic [63:0]      p0_a, p0_b, p1_a, p1_b;
   logic [3:0]       p0_op, p1_op;
   logic [TAG_W-1:0] p0_tag, p1_tag;
   logic             r0_valid, r1_valid;
   logic             r0_ready, r1_ready;
   logic [63:0]      r0_result, r1_result;
   logic             r0_zero, r1_zero;
   logic [TAG_W-1:0] r0_tag, r1_tag;
   logic             busy;

   int checks;
   int errors;

   alu_share_arbiter #(.TAG_W(TAG_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .p0_valid(p0_valid), .p0_ready(p0_ready), .p0_a(p0_a), .p0_b(p0_b),
      .p0_op(p0_op), .p0_tag(p0_tag),
      .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_a(p1_a), .p1_b(p1_b),
      .p1_op(p1_op), .p1_tag(p1_tag),
      .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_result(r0_result),
      .r0_zero(r0_zero), .r0_tag(r0_tag),
      .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_result(r1_result),
      .r1_zero(r1_zero), .r1_tag(r1_tag),
      .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic do_reset();
      rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // drives one request on a port, waits for accept and checks the response
   task automatic run_op(input int port, input logic [63:0] a, input logic [63:0] b,
                         input logic [3:0] op, input logic [TAG_W-1:0] tag,
                         input logic [63:0] exp_res, input logic exp_zero, input string name);
      int n;
      @(negedge clk);
      r0_ready = 1'b1;
      r1_ready = 1'b1;
      if (port == 1) begin
         p1_a = a; p1_b = b; p1_op = op; p1_tag = tag; p1_valid = 1'b1;
      end else begin
         p0_a = a; p0_b = b; p0_op = op; p0_tag = tag; p0_valid = 1'b1;
      end
      #1;
      n = 0;
      while (!((port == 1) ? p1_ready : p0_ready) && n < 20) begin
         @(negedge clk);
         #1;
         n++;
      end
      checks++;
      if (n >= 20) begin
         errors++;
         $display("FAIL %s accept: no ready within 20 cycles", name);
         p0_valid = 1'b0;
         p1_valid = 1'b0;
         return;
      end
      @(posedge clk);
      @(negedge clk);
      p0_valid = 1'b0;
      p1_valid = 1'b0;
      checks++;
      if (busy !== 1'b1 || p0_ready !== 1'b0 || p1_ready !== 1'b0) begin
         errors++;
         $display("FAIL %s exec: busy=%b p0_ready=%b p1_ready=%b want 1 0 0", name, busy, p0_ready, p1_ready);
      end
      @(negedge clk);
      checks++;
      if (port == 1) begin
         if (r1_valid !== 1'b1 || r1_result !== exp_res || r1_zero !== exp_zero ||
             r1_tag !== tag || r0_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s resp1: v=%b res=%h z=%b tag=%h r0v=%b want 1 %h %b %h 0",
                     name, r1_valid, r1_result, r1_zero, r1_tag, r0_valid, exp_res, exp_zero, tag);
         end
      end else begin
         if (r0_valid !== 1'b1 || r0_result !== exp_res || r0_zero !== exp_zero ||
             r0_tag !== tag || r1_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s resp0: v=%b res=%h z=%b tag=%h r1v=%b want 1 %h %b %h 0",
                     name, r0_valid, r0_result, r0_zero, r0_tag, r1_valid, exp_res, exp_zero, tag);
         end
      end
      @(negedge clk);
      checks++;
      if (r0_valid !== 1'b0 || r1_valid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL %s release: r0v=%b r1v=%b busy=%b want 0 0 0", name, r0_valid, r1_valid, busy);
      end
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      checks++;
      if (r0_valid !== 1'b0 || r1_valid !== 1'b0 || p0_ready !== 1'b0 ||
          p1_ready !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_ctrl: r0v=%b r1v=%b p0r=%b p1r=%b busy=%b want all 0",
                  r0_valid, r1_valid, p0_ready, p1_ready, busy);
      end
      checks++;
      if (r0_result !== 64'd0 || r0_zero !== 1'b0 || r0_tag !== '0 ||
          r1_result !== 64'd0 || r1_zero !== 1'b0 || r1_tag !== '0) begin
         errors++;
         $display("FAIL reset_data: r0=%h/%b/%h r1=%h/%b/%h want all 0",
                  r0_result, r0_zero, r0_tag, r1_result, r1_zero, r1_tag);
      end
   endtask

   task automatic test_add();
      run_op(0, 64'd5, 64'd7, 4'b0010, 4'd3, 64'd12, 1'b0, "add");
   endtask

   task automatic test_sub_zero();
      run_op(1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 4'b0110, 4'd1, 64'd0, 1'b1, "sub_eq");
      run_op(1, 64'd0, 64'd1, 4'b0110, 4'd2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, "sub_wrap");
   endtask

   task automatic test_opcodes();
      run_op(0, 64'd3, 64'd9, 4'b1111, 4'd4, 64'd0, 1'b1, "slt_lt");
      run_op(0, 64'd9, 64'd3, 4'b1111, 4'd5, 64'd1, 1'b0, "slt_ge");
      run_op(0, 64'd9, 64'd3, 4'b0101, 4'd6, 64'd0, 1'b1, "undef");
      run_op(1, 64'hF0F0, 64'h0FF0, 4'b0000, 4'd7, 64'h00F0, 1'b0, "and");
      run_op(1, 64'hF000, 64'h000F, 4'b0001, 4'd8, 64'hF00F, 1'b0, "or");
      run_op(0, 64'd0, 64'hFFFF_FFFF_FFFF_FFF0, 4'b1100, 4'd9, 64'hF, 1'b0, "nor");
   endtask

   task automatic test_backpressure();
      int n;
      @(negedge clk);
      r0_ready = 1'b0;
      r1_ready = 1'b1;
      p0_a = 64'hFFFF_FFFF_FFFF_FFFF; p0_b = 64'd2; p0_op = 4'b0010; p0_tag = 4'd9;
      p0_valid = 1'b1;
      #1;
      n = 0;
      while (!p0_ready && n < 20) begin
         @(negedge clk);
         #1;
         n++;
      end
      checks++;
      if (n >= 20) begin
         errors++;
         $display("FAIL bp accept: no p0_ready within 20 cycles");
      end
      @(posedge clk);
      @(negedge clk);
      p0_valid = 1'b0;
      p1_a = 64'd100; p1_b = 64'd1; p1_op = 4'b0010; p1_tag = 4'd5;
      p1_valid = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (r0_valid !== 1'b1 || r0_result !== 64'd1 || r0_tag !== 4'd9 || r0_zero !== 1'b0 ||
             p1_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp hold%0d: r0v=%b res=%h tag=%h z=%b p1r=%b want 1 1 9 0 0",
                     i, r0_valid, r0_result, r0_tag, r0_zero, p1_ready);
         end
         @(negedge clk);
      end
      r0_ready = 1'b1;
      #1;
      checks++;
      if (p1_ready !== 1'b0) begin
         errors++;
         $display("FAIL bp hs_cycle: p1_ready=%b want 0", p1_ready);
      end
      @(negedge clk);
      #1;
      checks++;
      if (r0_valid !== 1'b0 || p1_ready !== 1'b1) begin
         errors++;
         $display("FAIL bp next_idle: r0v=%b p1r=%b want 0 1", r0_valid, p1_ready);
      end
      @(posedge clk);
      @(negedge clk);
      p1_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (r1_valid !== 1'b1 || r1_result !== 64'd101 || r1_tag !== 4'd5 || r0_result !== 64'd1) begin
         errors++;
         $display("FAIL bp p1_resp: r1v=%b res=%h tag=%h r0res=%h want 1 65 5 1",
                  r1_valid, r1_result, r1_tag, r0_result);
      end
      @(negedge clk);
   endtask

   task automatic test_contention();
      int grants[4];
      int when[4];
      int g;
      int exp_g;
      p0_a = 64'd1; p0_b = 64'd1; p0_op = 4'b0010; p0_tag = 4'd1;
      p1_a = 64'd2; p1_b = 64'd2; p1_op = 4'b0010; p1_tag = 4'd2;
      p0_valid = 1'b1;
      p1_valid = 1'b1;
      r0_ready = 1'b1;
      r1_ready = 1'b1;
      do_reset();
      g = 0;
      for (int i = 0; i < 30 && g < 4; i++) begin
         #1;
         if (p0_ready || p1_ready) begin
            grants[g] = p1_ready ? 1 : 0;
            when[g]   = i;
            g++;
         end
         @(negedge clk);
      end
      checks++;
      if (g != 4) begin
         errors++;
         $display("FAIL contention count: saw %0d grants want 4", g);
      end
      for (int k = 0; k < g; k++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
         exp_g = 0;
`else
         exp_g = k % 2;
`endif
         checks++;
         if (grants[k] != exp_g) begin
            errors++;
            $display("FAIL contention grant%0d: got p%0d want p%0d", k, grants[k], exp_g);
         end
         if (k > 0) begin
            checks++;
            if (when[k] - when[k-1] != 3) begin
               errors++;
               $display("FAIL contention spacing%0d: got %0d want 3", k, when[k] - when[k-1]);
            end
         end
      end
      p0_valid = 1'b0;
      p1_valid = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic test_reset_exec();
      int n;
      int seen;
      @(negedge clk);
      r0_ready = 1'b1;
      r1_ready = 1'b1;
      p0_a = 64'd4; p0_b = 64'd4; p0_op = 4'b0010; p0_tag = 4'd3;
      p0_valid = 1'b1;
      #1;
      n = 0;
      while (!p0_ready && n < 20) begin
         @(negedge clk);
         #1;
         n++;
      end
      checks++;
      if (n >= 20) begin
         errors++;
         $display("FAIL rst_exec accept: no p0_ready within 20 cycles");
      end
      @(posedge clk);
      @(negedge clk);
      p0_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      checks++;
      if (busy !== 1'b0 || r0_valid !== 1'b0) begin
         errors++;
         $display("FAIL rst_exec async: busy=%b r0v=%b want 0 0", busy, r0_valid);
      end
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      repeat (4) begin
         @(negedge clk);
         if (r0_valid || r1_valid || busy) seen++;
      end
      checks++;
      if (seen != 0) begin
         errors++;
         $display("FAIL rst_exec discard: activity on %0d cycles want 0", seen);
      end
      p1_a = 64'd0; p1_b = 64'd0; p1_op = 4'b0010; p1_tag = 4'd2;
      p0_valid = 1'b1;
      p1_valid = 1'b1;
      #1;
      checks++;
      if (p0_ready !== 1'b1 || p1_ready !== 1'b0) begin
         errors++;
         $display("FAIL rst_exec first_grant: p0r=%b p1r=%b want 1 0", p0_ready, p1_ready);
      end
      @(posedge clk);
      @(negedge clk);
      p0_valid = 1'b0;
      p1_valid = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   initial begin
      checks   = 0;
      errors   = 0;
      rst_n    = 1'b0;
      p0_valid = 1'b0; p1_valid = 1'b0;
      p0_a = '0; p0_b = '0; p0_op = '0; p0_tag = '0;
      p1_a = '0; p1_b = '0; p1_op = '0; p1_tag = '0;
      r0_ready = 1'b0; r1_ready = 1'b0;
      test_reset();
      test_add();
      test_sub_zero();
      test_opcodes();
      test_backpressure();
      test_contention();
      test_reset_exec();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
